alvio_ready_init_ctrl: RTL and testbench

Initialization and reconfiguration sequencer for the active-list ready-bit RAM (ALVIO ready bits). After reset, and on each dynamic-reconfiguration request, it drains the active list, then clears every entry of the active partitions through one dedicated RAM write port, one entry per cycle. It raises `alReadyBitReady_o` only when the RAM contents are valid. The block sits beside the ready-bit RAM in the dispatch/commit area. Dispatch treats `alReadyBitReady_o` low as a stall.

---
 rtl/alvio_ready_init_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alvio_ready_init_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alvio_ready_init_ctrl.sv
// alvio_ready_init_ctrl
// Sequencer that clears the active-list ready-bit RAM after reset and on every
// dynamic reconfiguration. A reconfiguration first drains the active list and
// then writes zero to the entries through a dedicated RAM write port, one entry
// per cycle. alReadyBitReady_o is high only while the RAM contents are valid.
//
// Build option:
//   ALVIO_INIT_SKIP_GATED_EN  defined: clear only the partitions that are active
//                             in the mask latched on entry to the clear (an
//                             all-zero mask is treated as partition 0 active).
//                             undefined: ignore the mask and clear 0..DEPTH-1.
module alvio_ready_init_ctrl #(
    parameter int DEPTH         = 16,
    parameter int INDEX         = 4,
    parameter int WIDTH         = 8,
    parameter int NUM_PARTS     = 4,
    parameter int NUM_PARTS_LOG = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PARTS-1:0] alPartitionActive_i,
    input  logic                 reconfigReq_i,
    input  logic                 alEmpty_i,
    output logic                 we_o,
    output logic [INDEX-1:0]     addrWr_o,
    output logic [WIDTH-1:0]     dataWr_o,
    output logic                 alReadyBitReady_o,
    output logic                 reconfigAck_o
);

    localparam int PS = DEPTH / NUM_PARTS;
    localparam int PW = (NUM_PARTS_LOG > 0) ? NUM_PARTS_LOG : 1;
    localparam logic [INDEX-1:0] LAST_OFF = INDEX'(PS - 1);

    typedef enum logic [1:0] {
        START = 2'd0,
        CLEAR = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_n;
    logic [NUM_PARTS-1:0]   mask_q, mask_n;
    logic [PW-1:0]          part_q, part_n;
    logic [INDEX-1:0]       off_q, off_n;
    logic                   pend_q, pend_n;
    logic                   we_n;
    logic [INDEX-1:0]       addr_n;
    logic                   ready_n;
    logic                   ack_n;

    logic [NUM_PARTS-1:0]   start_mask;
    logic [PW-1:0]          start_part;
    logic [PW:0]            nxt;

    // Mask actually used for a clear, taken from the live partition enables.
    function automatic logic [NUM_PARTS-1:0] eff_mask(input logic [NUM_PARTS-1:0] m);
`ifdef ALVIO_INIT_SKIP_GATED_EN
        return (m == '0) ? NUM_PARTS'(1) : m;
`else
        // Mask has no effect in this build: every partition is cleared.
        return {NUM_PARTS{1'b1}} | m;
`endif
    endfunction

    // Lowest active partition of a mask.
    function automatic logic [PW-1:0] first_part(input logic [NUM_PARTS-1:0] m);
        logic [PW-1:0] r;
        r = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (m[i]) r = PW'(i);
        end
        return r;
    endfunction

    // {found, index} of the lowest active partition strictly above p.
    function automatic logic [PW:0] next_part(input logic [NUM_PARTS-1:0] m,
                                              input logic [PW-1:0]        p);
        logic [PW:0] r;
        r = '0;
        for (int i = NUM_PARTS - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(p))) r = {1'b1, PW'(i)};
        end
        return r;
    endfunction

    // First RAM address of partition p.
    function automatic logic [INDEX-1:0] part_base(input logic [PW-1:0] p);
        return INDEX'(int'(p) * PS);
    endfunction

    assign start_mask = eff_mask(alPartitionActive_i);
    assign start_part = first_part(start_mask);
    assign nxt        = next_part(mask_q, part_q);

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_n = state_q;
        mask_n  = mask_q;
        part_n  = part_q;
        off_n   = off_q;
        pend_n  = pend_q;
        we_n    = 1'b0;
        addr_n  = addrWr_o;
        ready_n = 1'b0;
        ack_n   = 1'b0;
        case (state_q)
            START: begin
                // Post-reset clear: never acknowledged.
                state_n = CLEAR;
                mask_n  = start_mask;
                part_n  = start_part;
                off_n   = '0;
                addr_n  = part_base(start_part);
                we_n    = 1'b1;
                pend_n  = 1'b0;
            end
            CLEAR: begin
                we_n = 1'b1;
                if (off_q == LAST_OFF) begin
                    if (nxt[PW]) begin
                        // Jump over gated partitions to the next active one.
                        part_n = nxt[PW-1:0];
                        off_n  = '0;
                        addr_n = part_base(nxt[PW-1:0]);
                    end else begin
                        // Last entry of the highest active partition written.
                        state_n = READY;
                        we_n    = 1'b0;
                        ready_n = 1'b1;
                        ack_n   = pend_q;
                        pend_n  = 1'b0;
                    end
                end else begin
                    off_n  = off_q + INDEX'(1);
                    addr_n = addrWr_o + INDEX'(1);
                end
            end
            READY: begin
                if (reconfigReq_i) begin
                    state_n = DRAIN;
                end else begin
                    ready_n = 1'b1;
                end
            end
            DRAIN: begin
                if (alEmpty_i) begin
                    state_n = CLEAR;
                    mask_n  = start_mask;
                    part_n  = start_part;
                    off_n   = '0;
                    addr_n  = part_base(start_part);
                    we_n    = 1'b1;
                    pend_n  = 1'b1;
                end
            end
            default: begin
                state_n = START;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= START;
            mask_q            <= '0;
            part_q            <= '0;
            off_q             <= '0;
            pend_q            <= 1'b0;
            we_o              <= 1'b0;
            addrWr_o          <= '0;
            dataWr_o          <= '0;
            alReadyBitReady_o <= 1'b0;
            reconfigAck_o     <= 1'b0;
        end else begin
            state_q           <= state_n;
            mask_q            <= mask_n;
            part_q            <= part_n;
            off_q             <= off_n;
            pend_q            <= pend_n;
            we_o              <= we_n;
            addrWr_o          <= addr_n;
            dataWr_o          <= '0;
            alReadyBitReady_o <= ready_n;
            reconfigAck_o     <= ack_n;
        end
    end

endmodule

// File: tb/tb_alvio_ready_init_ctrl.sv
// Testbench for alvio_ready_init_ctrl: expected write addresses are queued by
// the stimulus side from a partition-level model; a negedge monitor pops and
// compares every write the DUT presents. Honours ALVIO_INIT_SKIP_GATED_EN.
module tb_alvio_ready_init_ctrl;

    localparam int DEPTH = 16;
    localparam int INDEX = 4;
    localparam int WIDTH = 8;
    localparam int NP    = 4;
    localparam int NPL   = 2;
    localparam int PS    = DEPTH / NP;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    mask;
    logic             req;
    logic             empty;
    logic             we_o;
    logic [INDEX-1:0] addrWr_o;
    logic [WIDTH-1:0] dataWr_o;
    logic             ready_o;
    logic             ack_o;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_seen = 0;
    int exp_q[$];

    alvio_ready_init_ctrl #(
        .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
        .NUM_PARTS(NP), .NUM_PARTS_LOG(NPL)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .alPartitionActive_i (mask),
        .reconfigReq_i       (req),
        .alEmpty_i           (empty),
        .we_o                (we_o),
        .addrWr_o            (addrWr_o),
        .dataWr_o            (dataWr_o),
        .alReadyBitReady_o   (ready_o),
        .reconfigAck_o       (ack_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: ascending list of every entry of every partition to clear.
    task automatic push_expected(input logic [NP-1:0] m, output int n);
        logic [NP-1:0] em;
`ifdef ALVIO_INIT_SKIP_GATED_EN
        em = (m == '0) ? 4'b0001 : m;
`else
        em = 4'b1111;
`endif
        n = 0;
        for (int p = 0; p < NP; p++) begin
            if (em[p]) begin
                for (int o = 0; o < PS; o++) begin
                    exp_q.push_back(p * PS + o);
                    n++;
                end
            end
        end
    endtask

    // Monitor: every presented write must match the next queued address.
    always @(negedge clk) begin
        if (reset) begin
            if (we_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(addrWr_o), 32'hFFFF_FFFF);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(addrWr_o), 32'(e));
                    check("write_data", 32'(dataWr_o), 0);
                    check("ready_low_while_writing", 32'(ready_o), 0);
                end
            end
            if (ack_o) begin
                ack_seen++;
                check("ack_with_ready", 32'(ready_o), 1);
            end
        end
    end

    // Hold reset for 3 cycles, then run and time the post-reset clear.
    task automatic do_reset(input logic [NP-1:0] m);
        int n, cnt, a0;
        @(negedge clk);
        reset = 1'b0;
        req   = 1'b0;
        empty = 1'b0;
        mask  = m;
        a0    = ack_seen;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(we_o), 0);
        check("rst_addr_data", 32'({addrWr_o, dataWr_o}), 0);
        check("rst_ready_ack", 32'({ready_o, ack_o}), 0);
        push_expected(m, n);
        reset = 1'b1;
        cnt = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cnt++;
            if (ready_o) break;
            if (cnt > 100) begin
                check("post_reset_timeout", 32'(cnt), 32'(n + 1));
                return;
            end
        end
        check("post_reset_ready_edge", 32'(cnt), 32'(n + 1));
        check("post_reset_no_ack", 32'(ack_o), 0);
        check("post_reset_all_written", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        check("post_reset_ack_count", 32'(ack_seen - a0), 0);
        check("post_reset_ready_held", 32'(ready_o), 1);
    endtask

    // Reconfiguration from READY. drain = cycles alEmpty_i stays low in DRAIN.
    // use_mid changes the mask after 2 writes; abort resets after the 6th write.
    task automatic reconfig(input logic [NP-1:0] m, input int drain,
                            input logic [NP-1:0] mid_m, input bit use_mid,
                            input bit abort);
        int n, cnt, a0;
        a0 = ack_seen;
        @(negedge clk);
        mask  = m;
        req   = 1'b1;
        empty = (drain == 0);
        @(posedge clk);
        #1;
        check("reconfig_ready_drop", 32'(ready_o), 0);
        repeat (drain) begin
            @(posedge clk);
            #1;
            check("drain_no_write", 32'({we_o, ready_o}), 0);
        end
        @(negedge clk);
        push_expected(m, n);
        empty = 1'b1;
        cnt = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cnt++;
            if (use_mid && cnt == 2) mask = mid_m;
            if (abort && cnt == 6) begin
                @(negedge clk);
                #2;
                reset = 1'b0;
                req   = 1'b0;
                #1;
                check("abort_we", 32'(we_o), 0);
                check("abort_ready_ack", 32'({ready_o, ack_o}), 0);
                check("abort_addr", 32'(addrWr_o), 0);
                check("abort_no_ack", 32'(ack_seen - a0), 0);
                exp_q.delete();
                return;
            end
            if (ready_o) break;
            if (cnt > 100) begin
                check("reconfig_timeout", 32'(cnt), 32'(n + 1));
                req = 1'b0;
                return;
            end
        end
        check("reconfig_ready_edge", 32'(cnt), 32'(n + 1));
        check("reconfig_ack", 32'(ack_o), 1);
        check("reconfig_all_written", 32'(exp_q.size()), 0);
        req   = 1'b0;
        empty = 1'($urandom);
        @(posedge clk);
        #1;
        check("ack_one_cycle", 32'(ack_o), 0);
        check("ready_held", 32'(ready_o), 1);
        check("reconfig_ack_count", 32'(ack_seen - a0), 1);
    endtask

    initial begin
        reset = 1'b0;
        mask  = '0;
        req   = 1'b0;
        empty = 1'b0;

        do_reset(4'b1111);
        do_reset(4'b0101);
        reconfig(4'b0011, 5, 4'b0000, 1'b0, 1'b0);
        reconfig(4'b1111, 1, 4'b0001, 1'b1, 1'b0);
        reconfig(4'b0110, 0, 4'b0000, 1'b0, 1'b0);
        reconfig(4'b1111, 2, 4'b0000, 1'b0, 1'b1);
        do_reset(4'b0110);
        do_reset(4'b0000);
        reconfig(4'b0000, 3, 4'b0000, 1'b0, 1'b0);
        reconfig(4'b1000, 0, 4'b0000, 1'b0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            reconfig(4'($urandom), int'($urandom_range(0, 6)),
                     4'($urandom), 1'($urandom), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
